// File: rtl/maj_stim_if.sv
// maj_stim_if -- bundle of control, status and DUT-facing signals for the
// majority stimulus/check stage.
//   master : run controller side (drives start/abort/vec_limit/lfsr_sel/seed)
//            plus the majority netlist output y_dut; observes status
//   slave  : maj_stim_checker side (consumes controls and y_dut, drives
//            x_out and all status/result signals)
interface maj_stim_if #(
  parameter int N      = 41,
  parameter int MCNT_W = 32
);
  logic              start;
  logic              abort;
  logic [N:0]        vec_limit;
  logic              lfsr_sel;
  logic [N-1:0]      seed;
  logic [N-1:0]      x_out;
  logic              y_dut;
  logic              busy;
  logic              done;
  logic [N:0]        vec_cnt;
  logic [MCNT_W-1:0] mismatch_cnt;
  logic [N-1:0]      first_fail_vec;
  logic              first_fail_vld;

  modport master (
    output start, abort, vec_limit, lfsr_sel, seed, y_dut,
    input  x_out, busy, done, vec_cnt, mismatch_cnt, first_fail_vec, first_fail_vld
  );

  modport slave (
    input  start, abort, vec_limit, lfsr_sel, seed, y_dut,
    output x_out, busy, done, vec_cnt, mismatch_cnt, first_fail_vec, first_fail_vld
  );
endinterface

// File: rtl/maj_stim_checker.sv
// maj_stim_checker -- drives a mapped N-input majority netlist with a vector
// sequence, holds each vector SETTLE+1 cycles, samples y_dut on the edge that
// ends the hold window and compares it with a popcount majority reference.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    maj_stim_if.slave: start/abort/vec_limit/lfsr_sel/seed/y_dut in;
//          x_out/busy/done/vec_cnt/mismatch_cnt/first_fail_vec/first_fail_vld out
// Optional feature: define MAJ_LFSR_EN to allow a Galois LFSR vector source
// (lfsr_sel=1 at start). Without it lfsr_sel and seed are ignored.
module maj_stim_checker #(
  parameter int N      = 41,
  parameter int THRESH = (N + 1) / 2,
  parameter int SETTLE = 2,
  parameter int MCNT_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  maj_stim_if.slave  bus
);
  localparam int              PCW         = $clog2(N + 1);
  localparam int              SW          = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [N:0]      FULL        = {1'b1, {N{1'b0}}};
  localparam logic [N:0]      ONE_W       = {{N{1'b0}}, 1'b1};
  localparam logic [N-1:0]    ONE_X       = {{(N-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE);
  localparam logic [PCW-1:0]  THRESH_P    = PCW'(THRESH);
  localparam logic [MCNT_W-1:0] MCNT_MAX  = {MCNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  // Full-width popcount; PCW bits always hold N without truncation.
  function automatic logic [PCW-1:0] popcount(input logic [N-1:0] v);
    logic [PCW-1:0] c;
    c = {PCW{1'b0}};
    for (int i = 0; i < N; i++) c = c + PCW'(v[i]);
    return c;
  endfunction

`ifdef MAJ_LFSR_EN
  // Low tap of the feedback polynomial: x^41+x^3+1 and x^5+x^3+1 both tap bit 2.
  localparam int           TAP_LO    = ((N == 41) || (N == 5)) ? 2 : 0;
  localparam logic [N-1:0] LFSR_MASK = (ONE_X << (N - 1)) | (ONE_X << TAP_LO);

  // Right-shifting Galois step; a nonzero state never reaches zero.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] l);
    return {1'b0, l[N-1:1]} ^ (l[0] ? LFSR_MASK : {N{1'b0}});
  endfunction
`endif

  state_t            r_state, w_state_nxt;
  logic [SW-1:0]     r_settle, w_settle_nxt;
  logic [N-1:0]      r_x, w_x_nxt;
  logic [N:0]        r_limit, w_limit_nxt;
  logic [N:0]        r_vec_cnt, w_vec_cnt_nxt;
  logic [MCNT_W-1:0] r_mcnt, w_mcnt_nxt;
  logic [N-1:0]      r_ff_vec, w_ff_vec_nxt;
  logic              r_ff_vld, w_ff_vld_nxt;
  logic              r_busy, r_done;

  logic [N-1:0]      w_first_vec;   // vector loaded on a start edge
  logic [N:0]        w_start_limit; // effective run length latched at start
  logic [N-1:0]      w_x_adv;       // successor of the current vector
  logic              w_y_ref;
  logic              w_mis;
  logic [N:0]        w_cnt_inc;

`ifdef MAJ_LFSR_EN
  logic              r_lfsr_mode, w_lfsr_mode_nxt;
  logic [N-1:0]      r_lfsr, w_lfsr_nxt;
  logic [N-1:0]      w_seed_eff;
  logic [N-1:0]      w_lfsr_adv;
`else
  logic              w_unused_cfg;
  assign w_unused_cfg = ^{bus.lfsr_sel, bus.seed};
`endif

  assign w_y_ref   = (popcount(r_x) >= THRESH_P);
  assign w_mis     = (bus.y_dut != w_y_ref);
  assign w_cnt_inc = r_vec_cnt + ONE_W;

  // Start-time vector source selection, first vector and clamped run length.
  always_comb begin
    w_first_vec   = {N{1'b0}};
    w_start_limit = ((bus.vec_limit == {(N+1){1'b0}}) || (bus.vec_limit > FULL)) ? FULL : bus.vec_limit;
`ifdef MAJ_LFSR_EN
    w_seed_eff = (bus.seed == {N{1'b0}}) ? ONE_X : bus.seed;
    w_lfsr_adv = lfsr_step(r_lfsr);
    if (bus.lfsr_sel) begin
      w_first_vec = w_seed_eff;
      // LFSR period excludes the all-zero state.
      if ((bus.vec_limit == {(N+1){1'b0}}) || (bus.vec_limit >= FULL)) begin
        w_start_limit = FULL - ONE_W;
      end else begin
        w_start_limit = bus.vec_limit;
      end
    end else begin
      w_first_vec = {N{1'b0}};
    end
    w_x_adv = r_lfsr_mode ? w_lfsr_adv : (r_x + ONE_X);
`else
    w_x_adv = r_x + ONE_X;
`endif
  end

  // Next-state and datapath next values; abort outranks start and completion.
  always_comb begin
    w_state_nxt   = r_state;
    w_settle_nxt  = r_settle;
    w_x_nxt       = r_x;
    w_limit_nxt   = r_limit;
    w_vec_cnt_nxt = r_vec_cnt;
    w_mcnt_nxt    = r_mcnt;
    w_ff_vec_nxt  = r_ff_vec;
    w_ff_vld_nxt  = r_ff_vld;
`ifdef MAJ_LFSR_EN
    w_lfsr_mode_nxt = r_lfsr_mode;
    w_lfsr_nxt      = r_lfsr;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = {N{1'b0}};
        end else if (bus.start) begin
          w_state_nxt   = S_RUN;
          w_settle_nxt  = {SW{1'b0}};
          w_x_nxt       = w_first_vec;
          w_limit_nxt   = w_start_limit;
          w_vec_cnt_nxt = {(N+1){1'b0}};
          w_mcnt_nxt    = {MCNT_W{1'b0}};
          w_ff_vec_nxt  = {N{1'b0}};
          w_ff_vld_nxt  = 1'b0;
`ifdef MAJ_LFSR_EN
          w_lfsr_mode_nxt = bus.lfsr_sel;
          w_lfsr_nxt      = bus.lfsr_sel ? w_seed_eff : r_lfsr;
`endif
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          w_state_nxt = S_IDLE;
          w_x_nxt     = {N{1'b0}};
        end else if (r_settle == SETTLE_LAST) begin
          // Sample edge: score the held vector, then move on or finish.
          w_vec_cnt_nxt = w_cnt_inc;
          w_settle_nxt  = {SW{1'b0}};
          if (w_mis) begin
            w_mcnt_nxt = (r_mcnt != MCNT_MAX) ? (r_mcnt + {{(MCNT_W-1){1'b0}}, 1'b1}) : r_mcnt;
            if (!r_ff_vld) begin
              w_ff_vec_nxt = r_x;
              w_ff_vld_nxt = 1'b1;
            end else begin
              w_ff_vld_nxt = r_ff_vld;
            end
          end else begin
            w_mcnt_nxt = r_mcnt;
          end
          if (w_cnt_inc == r_limit) begin
            // Last vector stays visible on x_out while DONE.
            w_state_nxt = S_DONE;
          end else begin
            w_x_nxt = w_x_adv;
`ifdef MAJ_LFSR_EN
            w_lfsr_nxt = r_lfsr_mode ? w_lfsr_adv : r_lfsr;
`endif
          end
        end else begin
          w_settle_nxt = r_settle + {{(SW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_x_nxt     = {N{1'b0}};
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle  <= {SW{1'b0}};
      r_x       <= {N{1'b0}};
      r_limit   <= {(N+1){1'b0}};
      r_vec_cnt <= {(N+1){1'b0}};
      r_mcnt    <= {MCNT_W{1'b0}};
      r_ff_vec  <= {N{1'b0}};
      r_ff_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MAJ_LFSR_EN
      r_lfsr_mode <= 1'b0;
      r_lfsr      <= ONE_X;
`endif
    end else begin
      r_settle  <= w_settle_nxt;
      r_x       <= w_x_nxt;
      r_limit   <= w_limit_nxt;
      r_vec_cnt <= w_vec_cnt_nxt;
      r_mcnt    <= w_mcnt_nxt;
      r_ff_vec  <= w_ff_vec_nxt;
      r_ff_vld  <= w_ff_vld_nxt;
      r_busy    <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
`ifdef MAJ_LFSR_EN
      r_lfsr_mode <= w_lfsr_mode_nxt;
      r_lfsr      <= w_lfsr_nxt;
`endif
    end
  end

  assign bus.x_out          = r_x;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.vec_cnt        = r_vec_cnt;
  assign bus.mismatch_cnt   = r_mcnt;
  assign bus.first_fail_vec = r_ff_vec;
  assign bus.first_fail_vld = r_ff_vld;
endmodule
